// File: rtl/stopwatch_core_n.sv
// stopwatch_core_n: BCD mm:ss stopwatch / countdown with adjust mode and an
// optional lap FIFO. Define STOPWATCH_LAP_EN to build the lap FIFO; without it
// the lap inputs are ignored and the lap outputs are tied to zero.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_RUN     | counting on tick_1hz, up or down as chosen by dir
// S_PAUSED  | count frozen, waiting for pause_pulse
// S_ADJUST  | adj held high; tick_adj bumps the field chosen by sel
// S_EXPIRED | countdown reached 00:00; waits for pause_pulse
module stopwatch_core_n #(
  parameter int MIN_MAX   = 59,
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_adj,
  input  logic        pause_pulse,
  input  logic        adj,
  input  logic        sel,
  input  logic        dir,
  input  logic        lap_pulse,
  input  logic        lap_rd,
  output logic [3:0]  mt,
  output logic [3:0]  mo,
  output logic [3:0]  st,
  output logic [3:0]  so,
  output logic        running,
  output logic        expired,
  output logic        wrap,
  output logic [15:0] lap_data,
  output logic        lap_valid,
  output logic        lap_ovf
);

  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_ADJUST, S_EXPIRED} state_t;

  localparam logic [6:0] MIN_MAX_B = 7'(MIN_MAX);

  state_t     state_q, state_d;
  logic       prev_run_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       wrap_d, cnt_expire;
  logic       running_d, expired_d;
  logic [6:0] min_bin;
  logic       at_min_max, secs_zero, mins_zero;

  assign min_bin    = ({3'b000, mt} * 7'd10) + {3'b000, mo};
  assign at_min_max = (min_bin == MIN_MAX_B);
  assign secs_zero  = (st == 4'd0) && (so == 4'd0);
  assign mins_zero  = (mt == 4'd0) && (mo == 4'd0);

  // Digit update: counting in RUN, per-field increment in ADJUST.
  always_comb begin
    mt_d       = mt;
    mo_d       = mo;
    st_d       = st;
    so_d       = so;
    wrap_d     = 1'b0;
    cnt_expire = 1'b0;
    case (state_q)
      S_RUN: begin
        if (tick_1hz) begin
          if (!dir) begin
            if (so == 4'd9) begin
              so_d = 4'd0;
              if (st == 4'd5) begin
                st_d = 4'd0;
                if (at_min_max) begin
                  mt_d   = 4'd0;
                  mo_d   = 4'd0;
                  wrap_d = 1'b1;
                end else if (mo == 4'd9) begin
                  mo_d = 4'd0;
                  mt_d = mt + 4'd1;
                end else begin
                  mo_d = mo + 4'd1;
                end
              end else begin
                st_d = st + 4'd1;
              end
            end else begin
              so_d = so + 4'd1;
            end
          end else if (mins_zero && secs_zero) begin
            // already at 00:00: hold and expire
            cnt_expire = 1'b1;
          end else begin
            if (mins_zero && (st == 4'd0) && (so == 4'd1)) cnt_expire = 1'b1;
            if (so != 4'd0) begin
              so_d = so - 4'd1;
            end else begin
              so_d = 4'd9;
              if (st != 4'd0) begin
                st_d = st - 4'd1;
              end else begin
                st_d = 4'd5;
                if (mo != 4'd0) begin
                  mo_d = mo - 4'd1;
                end else begin
                  mo_d = 4'd9;
                  mt_d = mt - 4'd1;
                end
              end
            end
          end
        end
      end
      S_ADJUST: begin
        if (tick_adj) begin
          if (sel) begin
            if (so == 4'd9) begin
              so_d = 4'd0;
              st_d = (st == 4'd5) ? 4'd0 : st + 4'd1;
            end else begin
              so_d = so + 4'd1;
            end
          end else if (at_min_max) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
          end else if (mo == 4'd9) begin
            mo_d = 4'd0;
            mt_d = mt + 4'd1;
          end else begin
            mo_d = mo + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Next state: adj overrides everything; leaving ADJUST restores RUN or PAUSED.
  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = S_ADJUST;
    end else begin
      case (state_q)
        S_RUN:     if (pause_pulse) state_d = S_PAUSED;
                   else if (cnt_expire) state_d = S_EXPIRED;
        S_PAUSED:  if (pause_pulse) state_d = S_RUN;
        S_EXPIRED: if (pause_pulse) state_d = S_PAUSED;
        S_ADJUST:  state_d = prev_run_q ? S_RUN : S_PAUSED;
        default:   state_d = S_RUN;
      endcase
    end
  end

  // Status outputs decoded from the next state so they register with it.
  always_comb begin
    running_d = (state_d == S_RUN);
    expired_d = (state_d == S_EXPIRED);
  end

  // State, digits and status registers.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= S_RUN;
      prev_run_q <= 1'b0;
      mt         <= 4'd0;
      mo         <= 4'd0;
      st         <= 4'd0;
      so         <= 4'd0;
      running    <= 1'b1;
      expired    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (adj && (state_q != S_ADJUST)) prev_run_q <= (state_q == S_RUN);
      mt      <= mt_d;
      mo      <= mo_d;
      st      <= st_d;
      so      <= so_d;
      running <= running_d;
      expired <= expired_d;
      wrap    <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  localparam int PW = $clog2(LAP_DEPTH);

  logic [15:0]   mem [LAP_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
  logic [PW:0]   count, count_d;
  logic [15:0]   push_data, head_d;
  logic          full, do_push, do_pop, ovf_set;

  // FIFO control; the head is computed ahead so lap_data can be registered.
  always_comb begin
    push_data = {mt, mo, st, so};
    full      = (count == (PW+1)'(LAP_DEPTH));
    do_pop    = lap_rd && (count != '0);
    do_push   = lap_pulse && (!full || do_pop);
    ovf_set   = lap_pulse && full && !do_pop;
    rd_ptr_d  = do_pop  ? rd_ptr + PW'(1) : rd_ptr;
    wr_ptr_d  = do_push ? wr_ptr + PW'(1) : wr_ptr;
    case ({do_push, do_pop})
      2'b10:   count_d = count + (PW+1)'(1);
      2'b01:   count_d = count - (PW+1)'(1);
      default: count_d = count;
    endcase
    head_d = 16'h0000;
    if (count_d != '0) begin
      // the entry being written this cycle becomes head when the FIFO drains to it
      head_d = (do_push && (rd_ptr_d == wr_ptr)) ? push_data : mem[rd_ptr_d];
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_100mhz) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and lap outputs.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      lap_data  <= 16'h0000;
      lap_valid <= 1'b0;
      lap_ovf   <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_d;
      wr_ptr    <= wr_ptr_d;
      count     <= count_d;
      lap_data  <= head_d;
      lap_valid <= (count_d != '0);
      if (ovf_set) lap_ovf <= 1'b1;
    end
  end
`else
  logic lap_unused;
  assign lap_unused = &{1'b0, lap_pulse, lap_rd};
  assign lap_data   = 16'h0000;
  assign lap_valid  = 1'b0;
  assign lap_ovf    = 1'b0;
`endif

endmodule

// File: doc/stopwatch_core_n.md
STOPWATCH_CORE_N -- requirements
Module: stopwatch_core_n

Interface
REQ-001 SHALL have parameter MIN_MAX, default 59, which is the binary minutes terminal value; the legal range is 9..99.
REQ-002 SHALL have parameter LAP_DEPTH, default 4, which is the lap FIFO depth; it must be a power of two in the range 2..16.
REQ-003 SHALL have port clk_100mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port tick_1hz, input, 1 bit: single-cycle count strobe.
REQ-006 SHALL have port tick_adj, input, 1 bit: single-cycle adjust strobe (nominally 2 Hz).
REQ-007 SHALL have port pause_pulse, input, 1 bit: single-cycle, already-debounced pause toggle.
REQ-008 SHALL have port adj, input, 1 bit: level; 1 selects adjust mode.
REQ-009 SHALL have port sel, input, 1 bit: level; 1 adjusts seconds, 0 adjusts minutes.
REQ-010 SHALL have port dir, input, 1 bit: level; 0 counts up, 1 counts down.
REQ-011 SHALL have port lap_pulse, input, 1 bit: single-cycle lap capture request.
REQ-012 SHALL have port lap_rd, input, 1 bit: lap FIFO pop request.
REQ-013 SHALL have ports mt, mo, st, so, output, 4 bits each: BCD minutes tens/ones and seconds tens/ones.
REQ-014 SHALL have port running, output, 1 bit: 1 only in state RUN.
REQ-015 SHALL have port expired, output, 1 bit: 1 only in state EXPIRED.
REQ-016 SHALL have port wrap, output, 1 bit: single-cycle pulse on up-count rollover.
REQ-017 SHALL have port lap_data, output, 16 bits: FIFO head, {mt,mo,st,so}.
REQ-018 SHALL have ports lap_valid and lap_ovf, output, 1 bit each: FIFO non-empty, and sticky drop flag.

Function
REQ-019 SHALL implement the states RUN, PAUSED, ADJUST and EXPIRED, with every output registered.
REQ-020 SHALL, in RUN, on tick_1hz with dir=0, increment the seconds field; 59 wraps to 00 and carries into minutes; MIN_MAX:59 becomes 00:00 with wrap=1 for one cycle.
REQ-021 SHALL, in RUN, on tick_1hz with dir=1, decrement with borrow; 00:01 becomes 00:00, and the next state is EXPIRED.
REQ-022 SHALL, in RUN with dir=1, on a tick_1hz arriving while the count is already 00:00, hold 00:00 and enter EXPIRED.
REQ-023 SHALL toggle between RUN and PAUSED on pause_pulse; on simultaneous pause_pulse and tick_1hz in RUN, the tick is applied before the state leaves RUN.
REQ-024 SHALL, in PAUSED, ignore tick_1hz.
REQ-025 SHALL, on pause_pulse in EXPIRED, go to PAUSED and clear expired; tick_1hz is ignored in EXPIRED.
REQ-026 SHALL enter ADJUST from any state while adj=1, and record whether the prior state was RUN.
REQ-027 SHALL, in ADJUST, ignore tick_1hz and pause_pulse; ignoring pause_pulse here takes priority over the pause toggle in REQ-023.
REQ-028 SHALL, in ADJUST, increment only the field chosen by sel on each tick_adj, with no carry between fields: seconds 59 wraps to 00, minutes MIN_MAX wraps to 00; dir is ignored.
REQ-029 SHALL, when adj falls, return to RUN if the recorded prior state was RUN, and otherwise go to PAUSED; EXPIRED is never restored.
REQ-030 SHALL keep every BCD digit in the range 0..9 and the minutes value no greater than MIN_MAX.
REQ-031 SHALL, on lap_pulse in any state, push the digits registered before this cycle's update.
REQ-032 SHALL present the FIFO head on lap_data, hold lap_valid=1 while the FIFO is non-empty, and pop on lap_rd when lap_valid=1; lap_rd while empty is ignored.
REQ-033 SHALL, on a push while the FIFO is full and no pop occurs in the same cycle, drop the new entry and set lap_ovf until reset.
REQ-034 SHALL, on a simultaneous push and pop, perform both; the entry count is unchanged and lap_ovf is not set, even when full.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, clear all digits, go to state RUN, and set running=1, expired=0, wrap=0.
REQ-036 SHALL, on reset, empty the FIFO, set lap_valid=0 and lap_data=0, and clear lap_ovf.
REQ-037 SHALL give rst priority over every other input, including mid-adjust and while EXPIRED.

Configuration
REQ-038 SHALL, with STOPWATCH_LAP_EN defined, compile in the lap FIFO as specified above.
REQ-039 SHALL, with STOPWATCH_LAP_EN undefined, omit the FIFO, ignore lap_pulse and lap_rd, and drive lap_data, lap_valid and lap_ovf constantly to 0.

Verification
REQ-040 SHALL cover up-count rollover: MIN_MAX=59 at 59:58, apply 2 tick_1hz -> 59:59, then 00:00 with a one-cycle wrap pulse.
REQ-041 SHALL cover countdown expiry: dir=1 at 00:02, apply 3 tick_1hz -> 00:01, 00:00 with expired=1, digits held; pause_pulse -> PAUSED, expired=0.
REQ-042 SHALL cover pause persisting through adjust: PAUSED at 01:10, adj=1, sel=1, 3 tick_adj, then adj=0 -> 01:13; 10 tick_1hz -> still 01:13, running=0.
REQ-043 SHALL cover adjust wrap: MIN_MAX=9, minutes=9, sel=0, 1 tick_adj -> minutes 0, seconds unchanged.
REQ-044 SHALL cover FIFO overflow: LAP_DEPTH=4 with 5 lap_pulse at 00:01..00:05 -> lap_ovf=1; 4 pops return 0x0001..0x0004, then lap_valid=0.
REQ-045 SHALL cover reset mid-adjust: adj=1 at 03:07 with rst pulsed -> 00:00 with running=1 on adj=0.
